// File: rtl/quiz_round_arbiter.sv
// Quiz round controller and three-way buzzer arbiter.
// Arms a round on a host start edge, grants the answer slot to one contestant
// (round-robin among simultaneous presses), runs the arm/answer countdowns and
// raises the beep request when the answer time runs out.
module quiz_round_arbiter #(
  parameter int TICK_DIV    = 50000000,
  parameter int ARM_SECS    = 10,
  parameter int ANSWER_SECS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] con,
  input  logic       host_ok,
  input  logic       host_clear,
  output logic [2:0] chose,
  output logic       judge,
  output logic [2:0] foul,
  output logic [7:0] time_left,
  output logic [2:0] state,
  output logic       beep
);

  localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]    ARM_LOAD  = 8'(ARM_SECS);
  localparam logic [7:0]    ANS_LOAD  = 8'(ANSWER_SECS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_ANSWER  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    chose_q, chose_d;
  logic [2:0]    foul_q, foul_d;
  logic [7:0]    tl_q, tl_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          start_q;

  logic          start_rise;
  logic          tick;
  logic [2:0]    req;
  logic [1:0]    order [3];
  logic [2:0]    grant_vec;
  logic [1:0]    winner;
  logic          found;
  logic [1:0]    ptr_after_win;

  assign start_rise = start & ~start_q;
  assign tick       = (presc_q == PRESC_MAX);
  // Contestants who jumped the gun before the round was armed stay locked out.
  assign req        = con & ~foul_q;

  // Search order for this round: ptr, ptr+1, ptr+2 (mod 3).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_order
      logic [2:0] sum;
      assign sum       = {1'b0, ptr_q} + 3'(gi);
      assign order[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    end
  endgenerate

  // Pick the first eligible requester in round-robin order.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[order[k]]) begin
        found  = 1'b1;
        winner = order[k];
      end
    end
    grant_vec     = found ? (3'b001 << winner) : 3'b000;
    ptr_after_win = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
  end

  // Round FSM next-state, countdown and prescaler control.
  always_comb begin
    state_d = state_q;
    chose_d = chose_q;
    foul_d  = foul_q;
    tl_d    = tl_q;
    ptr_d   = ptr_q;
    presc_d = tick ? '0 : presc_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        foul_d = foul_q | con;
        if (start_rise) begin
          state_d = ST_ARMED;
          tl_d    = ARM_LOAD;
          presc_d = '0;
        end
      end
      ST_ARMED: begin
        // A press on the final tick still wins over expiry.
        if (found) begin
          state_d = ST_ANSWER;
          chose_d = grant_vec;
          ptr_d   = ptr_after_win;
          tl_d    = ANS_LOAD;
          presc_d = '0;
        end else if (tick) begin
          if (tl_q <= 8'd1) begin
            state_d = ST_DONE;
            chose_d = 3'b000;
            tl_d    = 8'd0;
            presc_d = '0;
          end else begin
            tl_d = tl_q - 8'd1;
          end
        end
      end
      ST_ANSWER: begin
        // host_ok beats the final tick, so an accepted answer never beeps.
        if (host_ok) begin
          state_d = ST_DONE;
        end else if (tick) begin
          if (tl_q <= 8'd1) begin
            state_d = ST_TIMEOUT;
            tl_d    = 8'd0;
            presc_d = '0;
          end else begin
            tl_d = tl_q - 8'd1;
          end
        end
      end
      ST_TIMEOUT: begin
        // The beep lasts one full prescaler period from entry.
        if (tick) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_rise) begin
          state_d = ST_ARMED;
          chose_d = 3'b000;
          tl_d    = ARM_LOAD;
          presc_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        chose_d = 3'b000;
        tl_d    = 8'd0;
      end
    endcase

    // Host abort overrides everything except reset; ptr keeps its fairness history.
    if (host_clear) begin
      state_d = ST_IDLE;
      chose_d = 3'b000;
      foul_d  = 3'b000;
      tl_d    = 8'd0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      chose_q <= 3'b000;
      foul_q  <= 3'b000;
      tl_q    <= 8'd0;
      ptr_q   <= 2'd0;
      presc_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chose_q <= chose_d;
      foul_q  <= foul_d;
      tl_q    <= tl_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
      start_q <= start;
    end
  end

  assign chose     = chose_q;
  assign judge     = |chose_q;
  assign foul      = foul_q;
  assign time_left = tl_q;
  assign state     = state_q;
  assign beep      = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_quiz_round_arbiter.sv
// Self-checking bench for quiz_round_arbiter (TICK_DIV=4, ARM_SECS=3, ANSWER_SECS=2).
// Each step drives inputs, queues the expected post-edge outputs, then compares.
module tb_quiz_round_arbiter;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] con;
  logic       host_ok;
  logic       host_clear;
  logic [2:0] chose;
  logic       judge;
  logic [2:0] foul;
  logic [7:0] time_left;
  logic [2:0] state;
  logic       beep;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic [2:0] c;
    logic       ok;
    logic       clr;
    logic [2:0] e_state;
    logic [2:0] e_chose;
    logic [2:0] e_foul;
    logic [7:0] e_tl;
    logic       e_beep;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[24];
  int   step_no = 0;

  quiz_round_arbiter #(
    .TICK_DIV   (4),
    .ARM_SECS   (3),
    .ANSWER_SECS(2)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .con       (con),
    .host_ok   (host_ok),
    .host_clear(host_clear),
    .chose     (chose),
    .judge     (judge),
    .foul      (foul),
    .time_left (time_left),
    .state     (state),
    .beep      (beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst_n, input logic st, input logic [2:0] c,
                              input logic ok, input logic clr, input logic [2:0] es,
                              input logic [2:0] ec, input logic [2:0] ef,
                              input logic [7:0] etl, input logic eb);
    vec_t v;
    v.rst_n = rst_n; v.st = st; v.c = c; v.ok = ok; v.clr = clr;
    v.e_state = es; v.e_chose = ec; v.e_foul = ef; v.e_tl = etl; v.e_beep = eb;
    return v;
  endfunction

  task automatic cmp(input string nm, input int stp, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, stp, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    reset      = v.rst_n;
    start      = v.st;
    con        = v.c;
    host_ok    = v.ok;
    host_clear = v.clr;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("step %0d: rst_n=%b st=%b con=%b ok=%b clr=%b -> state=%0d chose=%b judge=%b foul=%b tl=%0d beep=%b",
             step_no, v.rst_n, v.st, v.c, v.ok, v.clr, state, chose, judge, foul, time_left, beep);
    cmp("state",     step_no, 8'(state),     8'(e.e_state));
    cmp("chose",     step_no, 8'(chose),     8'(e.e_chose));
    cmp("judge",     step_no, 8'(judge),     8'(|e.e_chose));
    cmp("foul",      step_no, 8'(foul),      8'(e.e_foul));
    cmp("time_left", step_no, time_left,     e.e_tl);
    cmp("beep",      step_no, 8'(beep),      8'(e.e_beep));
    step_no++;
  endtask

  initial begin
    // Reset, arm, round-robin, single buzz, clear, false start.
    tbl[0]  = mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    tbl[1]  = mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    tbl[2]  = mk(1, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    tbl[3]  = mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b000, 3, 0);
    tbl[4]  = mk(1, 0, 3'b111, 0, 0, 2, 3'b001, 3'b000, 2, 0);
    tbl[5]  = mk(1, 0, 3'b000, 1, 0, 4, 3'b001, 3'b000, 2, 0);
    tbl[6]  = mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b000, 3, 0);
    tbl[7]  = mk(1, 0, 3'b111, 0, 0, 2, 3'b010, 3'b000, 2, 0);
    tbl[8]  = mk(1, 0, 3'b000, 1, 0, 4, 3'b010, 3'b000, 2, 0);
    tbl[9]  = mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b000, 3, 0);
    tbl[10] = mk(1, 0, 3'b111, 0, 0, 2, 3'b100, 3'b000, 2, 0);
    tbl[11] = mk(1, 0, 3'b000, 1, 0, 4, 3'b100, 3'b000, 2, 0);
    tbl[12] = mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b000, 3, 0);
    tbl[13] = mk(1, 0, 3'b111, 0, 0, 2, 3'b001, 3'b000, 2, 0);
    tbl[14] = mk(1, 0, 3'b000, 1, 0, 4, 3'b001, 3'b000, 2, 0);
    tbl[15] = mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b000, 3, 0);
    tbl[16] = mk(1, 0, 3'b010, 0, 0, 2, 3'b010, 3'b000, 2, 0);
    tbl[17] = mk(1, 0, 3'b000, 1, 0, 4, 3'b010, 3'b000, 2, 0);
    tbl[18] = mk(1, 0, 3'b000, 0, 1, 0, 3'b000, 3'b000, 0, 0);
    tbl[19] = mk(1, 0, 3'b100, 0, 0, 0, 3'b000, 3'b100, 0, 0);
    tbl[20] = mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b100, 3, 0);
    tbl[21] = mk(1, 0, 3'b101, 0, 0, 2, 3'b001, 3'b100, 2, 0);
    tbl[22] = mk(1, 0, 3'b000, 1, 0, 4, 3'b001, 3'b100, 2, 0);
    tbl[23] = mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b100, 3, 0);

    for (int i = 0; i < 24; i++) step(tbl[i]);

    // Fouled player alone: no grant, round expires 12 cycles after arming.
    for (int i = 1; i <= 12; i++) begin
      step(mk(1, 0, 3'b100, 0, 0, (i < 12) ? 3'd1 : 3'd4, 3'b000, 3'b100,
              (i < 4) ? 8'd3 : (i < 8) ? 8'd2 : (i < 12) ? 8'd1 : 8'd0, 0));
    end

    // Answer timeout: countdown 2->1->0, four beep cycles, then DONE.
    step(mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b100, 3, 0));
    step(mk(1, 0, 3'b001, 0, 0, 2, 3'b001, 3'b100, 2, 0));
    for (int i = 1; i <= 13; i++) begin
      step(mk(1, 0, 3'b000, 0, 0, (i < 8) ? 3'd2 : (i < 12) ? 3'd3 : 3'd4, 3'b001, 3'b100,
              (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0, (i >= 8 && i < 12) ? 1'b1 : 1'b0));
    end

    // host_ok on the final tick: DONE with time_left frozen, no beep.
    step(mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b100, 3, 0));
    step(mk(1, 0, 3'b010, 0, 0, 2, 3'b010, 3'b100, 2, 0));
    for (int i = 1; i <= 12; i++) begin
      step(mk(1, 0, 3'b000, (i == 8) ? 1'b1 : 1'b0, 0, (i < 8) ? 3'd2 : 3'd4, 3'b010, 3'b100,
              (i < 4) ? 8'd2 : 8'd1, 0));
    end

    // host_clear during ANSWER.
    step(mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b100, 3, 0));
    step(mk(1, 0, 3'b001, 0, 0, 2, 3'b001, 3'b100, 2, 0));
    step(mk(1, 0, 3'b000, 0, 1, 0, 3'b000, 3'b000, 0, 0));

    // Reset asserted while beeping in TIMEOUT.
    step(mk(1, 1, 3'b000, 0, 0, 1, 3'b000, 3'b000, 3, 0));
    step(mk(1, 0, 3'b010, 0, 0, 2, 3'b010, 3'b000, 2, 0));
    for (int i = 1; i <= 9; i++) begin
      step(mk(1, 0, 3'b000, 0, 0, (i < 8) ? 3'd2 : 3'd3, 3'b010, 3'b000,
              (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0, (i >= 8) ? 1'b1 : 1'b0));
    end
    step(mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    step(mk(1, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
